mod_exp_arbiter: RTL and testbench
==================================

// Module: mod_exp_arbiter
// PURPOSE
//  Round-robin arbiter/sequencer sharing one mod_exp engine among NREQ requesters (e.g. encrypt, decrypt, signing).
//  Accepts (a,e) jobs over valid/ready, drives the engine's level start/done protocol, captures z and
//  returns it with the requester id over a valid/ready response channel. Sits between the RSA clients and mod_exp.
// PARAMETERS
//  N_BIT  7  operand/result width; must equal the engine's n_bit
//  NREQ   2  number of requesters, 2..8; ID_W = clog2(NREQ) (localparam, min 1)
// PORTS
//  clk        in   1           clock; everything on rising edge
//  rst_n      in   1           asynchronous, active-low reset
//  req_valid  in   NREQ        job request per requester
//  req_ready  out  NREQ        one-hot accept; job i taken when req_valid[i]&req_ready[i]
//  req_a      in   NREQ*N_BIT  base, requester i at [i*N_BIT +: N_BIT]
//  req_e      in   NREQ*N_BIT  exponent, same packing
//  rsp_valid  out  1           result available
//  rsp_ready  in   1           consumer accepts result
//  rsp_z      out  N_BIT       a^e mod n
//  rsp_id     out  ID_W        index of requester owning rsp_z
//  busy       out  1           high in any state except IDLE
//  exp_a      out  N_BIT       engine base (registered)
//  exp_e      out  N_BIT       engine exponent (registered)
//  exp_start  out  1           engine start, level (registered)
//  exp_z      in   N_BIT       engine result, valid while exp_done=1
//  exp_done   in   1           engine done level; stays high until exp_start drops
// BEHAVIOUR
//  Reset: state IDLE, rr pointer 0, exp_start/rsp_valid/busy=0, exp_a/exp_e/rsp_z/rsp_id=0; req_ready=0.
//  Reset mid-job discards the job; engine shares rst_n so no drain needed.
//  FSM IDLE -> RUN -> DRAIN -> RESP -> IDLE.
//  IDLE: winner = first i with req_valid[i] scanning ptr, ptr+1, .. wrapping mod NREQ.
//    If any valid: req_ready[winner]=1 this cycle only (combinational from IDLE & valids), latch
//    exp_a/exp_e/rsp_id, ptr <= winner+1 (wrap NREQ-1 -> 0), go RUN. req_ready all 0 outside IDLE.
//  RUN: exp_start=1 (first high cycle = acceptance+1). On exp_done=1: rsp_z <= exp_z, go DRAIN.
//  DRAIN: exp_start=0; stay while exp_done=1; exp_done=0 -> RESP. Guarantees no stale done in next RUN.
//  RESP: rsp_valid=1, rsp_z/rsp_id stable; on rsp_ready go IDLE (rsp_valid low next cycle).
//    No new job accepted before handshake; earliest next req_ready is the cycle after rsp handshake.
//  exp_a/exp_e held constant from RUN entry until next acceptance (engine samples e in LOAD).
//  req_valid dropping while not granted: simply not selected; no requirement that requesters hold it.
//  Response occupancy: exactly one outstanding job; no buffering, no reordering.
//  Fairness: requester continuously valid waits at most NREQ-1 other jobs.
//  Width: ptr and rsp_id ID_W bits; ptr increment wraps explicitly at NREQ (not at 2^ID_W).
//  Simultaneous rsp_ready with rsp_valid on entry cycle: accepted immediately, one-cycle RESP.
// TESTING (reference engine: mod_exp n=79, n_bit=7, Rmodn=49, R2modn=31)
//  1 req0 a=5,e=3 alone -> req_ready[0] 1-cycle pulse, rsp_z=46, rsp_id=0, exp_start high only in RUN.
//  2 req0,req1 valid together from reset, rsp_ready=1 -> req0 (a=2,e=10 -> 76) served first, then req1 (a=5,e=0 -> 1); ptr back at 0.
//  3 Hold rsp_ready=0 20 cycles with req1 pending -> rsp_valid/rsp_z/rsp_id stable, req_ready=0, exp_start=0.
//  4 NREQ=3, all valid continuously for 6 jobs -> grant order 0,1,2,0,1,2.
//  5 Behavioural engine keeps exp_done high 3 cycles after exp_start drops -> RESP entered only after done low.
//  6 Assert rst_n low mid-RUN -> all outputs 0 asynchronously; after release, req2 a=3,e=4 -> rsp_z=2 (81 mod 79).

Source files
------------

// File: rtl/mod_exp_arbiter.sv
// Round-robin sequencer sharing one mod_exp engine among NREQ requesters.
// Jobs enter over valid/ready, run on the engine's level start/done protocol, and return with the requester id.
module mod_exp_arbiter #(
    parameter  int unsigned N_BIT = 7,
    parameter  int unsigned NREQ  = 2,
    localparam int unsigned ID_W  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*N_BIT-1:0] req_a,
    input  logic [NREQ*N_BIT-1:0] req_e,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [N_BIT-1:0]      rsp_z,
    output logic [ID_W-1:0]       rsp_id,
    output logic                  busy,
    output logic [N_BIT-1:0]      exp_a,
    output logic [N_BIT-1:0]      exp_e,
    output logic                  exp_start,
    input  logic [N_BIT-1:0]      exp_z,
    input  logic                  exp_done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [ID_W-1:0]    r_ptr;
    logic [ID_W-1:0]    w_winner;
    logic [ID_W-1:0]    w_ptr_nxt;
    logic               w_found;
    logic               w_accept;
    logic               w_capture;
    logic [N_BIT-1:0]   w_a_sel;
    logic [N_BIT-1:0]   w_e_sel;
    int unsigned        w_idx;

    logic               r_exp_start;
    logic               r_rsp_valid;
    logic               r_busy;
    logic [N_BIT-1:0]   r_exp_a;
    logic [N_BIT-1:0]   r_exp_e;
    logic [N_BIT-1:0]   r_rsp_z;
    logic [ID_W-1:0]    r_rsp_id;

    // First valid requester scanning from the pointer, wrapping at NREQ.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_idx    = 0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            w_idx = 32'(r_ptr) + k;
            if (w_idx >= NREQ) begin
                w_idx = w_idx - NREQ;
            end
            if (!w_found && (|(req_valid & (NREQ'(1) << w_idx)))) begin
                w_found  = 1'b1;
                w_winner = ID_W'(w_idx);
            end
        end
    end

    assign w_ptr_nxt = (w_winner == ID_W'(NREQ - 1)) ? '0 : w_winner + ID_W'(1);
    assign w_a_sel   = req_a[32'(w_winner) * N_BIT +: N_BIT];
    assign w_e_sel   = req_e[32'(w_winner) * N_BIT +: N_BIT];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state, one-cycle grant and datapath enables.
    always_comb begin
        w_state_nxt = r_state;
        req_ready   = '0;
        w_accept    = 1'b0;
        w_capture   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    req_ready   = NREQ'(1) << w_winner;
                    w_accept    = 1'b1;
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (exp_done) begin
                    w_capture   = 1'b1;
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // Wait out the engine's done level so the next RUN cannot see a stale done.
                if (!exp_done) begin
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Registered outputs decoded from the next state; operands held until the next acceptance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr       <= '0;
            r_exp_start <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_exp_a     <= '0;
            r_exp_e     <= '0;
            r_rsp_z     <= '0;
            r_rsp_id    <= '0;
        end else begin
            r_exp_start <= (w_state_nxt == S_RUN);
            r_rsp_valid <= (w_state_nxt == S_RESP);
            r_busy      <= (w_state_nxt != S_IDLE);
            if (w_accept) begin
                r_exp_a  <= w_a_sel;
                r_exp_e  <= w_e_sel;
                r_rsp_id <= w_winner;
                r_ptr    <= w_ptr_nxt;
            end
            if (w_capture) begin
                r_rsp_z <= exp_z;
            end
        end
    end

    assign exp_start = r_exp_start;
    assign rsp_valid = r_rsp_valid;
    assign busy      = r_busy;
    assign exp_a     = r_exp_a;
    assign exp_e     = r_exp_e;
    assign rsp_z     = r_rsp_z;
    assign rsp_id    = r_rsp_id;

endmodule

// File: tb/tb_mod_exp_arbiter.sv
// Directed bench for mod_exp_arbiter: a 2-requester and a 3-requester instance, each driving
// a behavioural mod_exp (n=79) whose done level may linger after start drops.
module tb_mod_exp_arbiter;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [1:0]  v2, rdy2;
    logic [13:0] a2, e2;
    logic        rv2, rrdy2, id2, busy2;
    logic [6:0]  z2;

    logic [2:0]  v3, rdy3;
    logic [20:0] a3, e3;
    logic        rv3, rrdy3, busy3;
    logic [1:0]  id3;
    logic [6:0]  z3;

    logic [6:0] ea [2];
    logic [6:0] ee [2];
    logic [6:0] ez [2];
    logic       es [2];
    logic       ed [2];
    int         hold_cfg [2];
    int         e_cnt [2];
    int         e_hold [2];
    logic       e_run [2];

    int n_vec = 0;
    int n_err = 0;

    mod_exp_arbiter #(.N_BIT(7), .NREQ(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .req_valid(v2), .req_ready(rdy2), .req_a(a2), .req_e(e2),
        .rsp_valid(rv2), .rsp_ready(rrdy2), .rsp_z(z2), .rsp_id(id2), .busy(busy2),
        .exp_a(ea[0]), .exp_e(ee[0]), .exp_start(es[0]), .exp_z(ez[0]), .exp_done(ed[0])
    );

    mod_exp_arbiter #(.N_BIT(7), .NREQ(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .req_valid(v3), .req_ready(rdy3), .req_a(a3), .req_e(e3),
        .rsp_valid(rv3), .rsp_ready(rrdy3), .rsp_z(z3), .rsp_id(id3), .busy(busy3),
        .exp_a(ea[1]), .exp_e(ee[1]), .exp_start(es[1]), .exp_z(ez[1]), .exp_done(ed[1])
    );

    function automatic logic [6:0] modexp(input logic [6:0] a, input logic [6:0] e);
        int r = 1;
        for (int i = 0; i < int'(e); i++) r = (r * int'(a)) % 79;
        return 7'(r);
    endfunction

    // Engine: 5 cycles after start rises, done goes high and holds until start drops plus hold_cfg cycles.
    always @(posedge clk or negedge rst_n) begin
        for (int g = 0; g < 2; g++) begin
            if (!rst_n) begin
                ed[g] <= 1'b0; ez[g] <= '0; e_run[g] <= 1'b0; e_cnt[g] <= 0; e_hold[g] <= 0;
            end else if (!ed[g] && !e_run[g] && es[g]) begin
                e_run[g] <= 1'b1; e_cnt[g] <= 3; ez[g] <= modexp(ea[g], ee[g]);
            end else if (e_run[g]) begin
                if (e_cnt[g] == 0) begin
                    ed[g] <= 1'b1; e_run[g] <= 1'b0; e_hold[g] <= hold_cfg[g];
                end else begin
                    e_cnt[g] <= e_cnt[g] - 1;
                end
            end else if (ed[g] && !es[g]) begin
                if (e_hold[g] == 0) ed[g] <= 1'b0;
                else e_hold[g] <= e_hold[g] - 1;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic wait_rsp2(input int budget);
        int n = 0;
        while (!rv2 && n < budget) begin @(negedge clk); n++; end
        check("rsp2_valid", 32'(rv2), 32'd1);
    endtask

    task automatic wait_rsp3(input int budget);
        int n = 0;
        while (!rv3 && n < budget) begin @(negedge clk); n++; end
        check("rsp3_valid", 32'(rv3), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int cnt;
        logic [1:0] exp_id [6];
        logic [6:0] exp_z [3];
        exp_id = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2};
        exp_z  = '{7'd46, 7'd76, 7'd2};
        hold_cfg[0] = 0; hold_cfg[1] = 0;
        v2 = '0; a2 = '0; e2 = '0; rrdy2 = 1'b0;
        v3 = '0; a3 = '0; e3 = '0; rrdy3 = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ready2", 32'(rdy2), 32'd0);
        check("rst_rv2", 32'(rv2), 32'd0);
        check("rst_busy2", 32'(busy2), 32'd0);
        check("rst_start2", 32'(es[0]), 32'd0);
        check("rst_z2", 32'(z2), 32'd0);
        check("rst_busy3", 32'(busy3), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: single job from req0
        v2 = 2'b01; a2 = {7'd0, 7'd5}; e2 = {7'd0, 7'd3};
        #1;
        check("t1_ready", 32'(rdy2), 32'd1);
        check("t1_start_idle", 32'(es[0]), 32'd0);
        @(negedge clk); v2 = 2'b00;
        check("t1_ready_off", 32'(rdy2), 32'd0);
        check("t1_start_run", 32'(es[0]), 32'd1);
        check("t1_busy", 32'(busy2), 32'd1);
        check("t1_exp_a", 32'(ea[0]), 32'd5);
        check("t1_exp_e", 32'(ee[0]), 32'd3);
        wait_rsp2(50);
        check("t1_z", 32'(z2), 32'd46);
        check("t1_id", 32'(id2), 32'd0);
        check("t1_start_resp", 32'(es[0]), 32'd0);
        rrdy2 = 1'b1;
        @(negedge clk);
        check("t1_rv_drop", 32'(rv2), 32'd0);
        check("t1_idle", 32'(busy2), 32'd0);

        // 2: both valid from reset, req0 first then req1, pointer wraps back to 0
        rst_n = 1'b0; @(negedge clk); rst_n = 1'b1; @(negedge clk);
        rrdy2 = 1'b1; v2 = 2'b11; a2 = {7'd5, 7'd2}; e2 = {7'd0, 7'd10};
        #1;
        check("t2_grant0", 32'(rdy2), 32'd1);
        @(negedge clk); v2 = 2'b10;
        wait_rsp2(50);
        check("t2_z0", 32'(z2), 32'd76);
        check("t2_id0", 32'(id2), 32'd0);
        @(negedge clk);
        check("t2_grant1", 32'(rdy2), 32'd2);
        @(negedge clk); v2 = 2'b00;
        wait_rsp2(50);
        check("t2_z1", 32'(z2), 32'd1);
        check("t2_id1", 32'(id2), 32'd1);
        @(negedge clk);
        v2 = 2'b11;
        #1;
        check("t2_ptr_wrap", 32'(rdy2), 32'd1);

        // 3: response held 20 cycles with req1 pending
        rrdy2 = 1'b0;
        @(negedge clk); v2 = 2'b10;
        wait_rsp2(50);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("t3_rv_hold", 32'(rv2), 32'd1);
            check("t3_z_hold", 32'(z2), 32'd76);
            check("t3_id_hold", 32'(id2), 32'd0);
            check("t3_no_grant", 32'(rdy2), 32'd0);
            check("t3_no_start", 32'(es[0]), 32'd0);
        end
        rrdy2 = 1'b1;
        @(negedge clk);
        check("t3_rv_drop", 32'(rv2), 32'd0);
        check("t3_next_grant", 32'(rdy2), 32'd2);
        @(negedge clk); v2 = 2'b00;
        wait_rsp2(50);
        check("t3_z1", 32'(z2), 32'd1);
        check("t3_id1", 32'(id2), 32'd1);
        @(negedge clk);

        // 4: NREQ=3 all continuously valid, grant order 0,1,2,0,1,2
        rrdy3 = 1'b1; v3 = 3'b111;
        a3 = {7'd3, 7'd2, 7'd5}; e3 = {7'd4, 7'd10, 7'd3};
        for (int k = 0; k < 6; k++) begin
            wait_rsp3(60);
            check("t4_id", 32'(id3), 32'(exp_id[k]));
            check("t4_z", 32'(z3), 32'(exp_z[exp_id[k]]));
            if (k == 5) v3 = 3'b000;
            @(negedge clk);
        end
        @(negedge clk);

        // 5: done lingers after start drops; RESP only after done falls
        hold_cfg[1] = 3;
        v3 = 3'b001;
        #1;
        check("t5_grant", 32'(rdy3), 32'd1);
        @(negedge clk); v3 = 3'b000;
        check("t5_start", 32'(es[1]), 32'd1);
        cnt = 0;
        while (es[1] && cnt < 50) begin @(negedge clk); cnt++; end
        check("t5_start_drop", 32'(es[1]), 32'd0);
        cnt = 0;
        while (!rv3 && cnt < 50) begin @(negedge clk); cnt++; end
        check("t5_gap", 32'(cnt), 32'd5);
        check("t5_done_low", 32'(ed[1]), 32'd0);
        check("t5_z", 32'(z3), 32'd46);
        @(negedge clk);
        hold_cfg[1] = 0;

        // 6: asynchronous reset mid-RUN, then req2 job
        v3 = 3'b010;
        #1;
        check("t6_grant", 32'(rdy3), 32'd2);
        @(negedge clk); v3 = 3'b000;
        @(negedge clk);
        check("t6_in_run", 32'(es[1]), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_busy", 32'(busy3), 32'd0);
        check("t6_rst_start", 32'(es[1]), 32'd0);
        check("t6_rst_rv", 32'(rv3), 32'd0);
        check("t6_rst_z", 32'(z3), 32'd0);
        check("t6_rst_a", 32'(ea[1]), 32'd0);
        check("t6_rst_e", 32'(ee[1]), 32'd0);
        check("t6_rst_ready", 32'(rdy3), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        v3 = 3'b100;
        #1;
        check("t6_grant2", 32'(rdy3), 32'd4);
        @(negedge clk); v3 = 3'b000;
        check("t6_exp_a", 32'(ea[1]), 32'd3);
        wait_rsp3(60);
        check("t6_z", 32'(z3), 32'd2);
        check("t6_id", 32'(id3), 32'd2);
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
